// File: rtl/bcd_time_counter.sv
// Stopwatch time base: four BCD digits shown as XX.XX (digit0 = tens of seconds,
// digit3 = hundredths). Contains a 0.01 s prescaler, toggle-button conditioning
// and a run/pause/done state machine. Supports count up or down, from zero, 99.99
// or a user preset.
// Optional feature: define LAP_EN to add a lap input that freezes the shown digits
// while the internal count keeps running.
module bcd_time_counter #(
  parameter int unsigned CLK_DIV     = 1000000,  // clock cycles per 0.01 s tick, >= 2
  parameter int unsigned SYNC_STAGES = 2         // button synchroniser depth, >= 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       toggle,
`ifdef LAP_EN
  input  logic       lap,
`endif
  input  logic [1:0] mode_sel,
  input  logic [3:0] init_val_one,
  input  logic [3:0] init_val_two,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic       running,
  output logic       done
);

  localparam int unsigned PresW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

  state_e                 state_q;
  logic [15:0]            count_q;    // {digit0, digit1, digit2, digit3}
  logic                   down_q;     // direction latched while idle
  logic                   running_q;
  logic                   done_q;
  logic [PresW-1:0]       presc_q;
  logic [SYNC_STAGES-1:0] tog_sync_q;
  logic                   tog_edge_q;

  logic        toggle_pulse;
  logic        tick;
  logic [15:0] preset;
  logic [15:0] count_step;
  logic        step_terminal;
  logic        idle_to_done;
  logic        run_to_done;
  logic [15:0] shown;

  function automatic logic [3:0] clamp9(input logic [3:0] v);
    return (v > 4'd9) ? 4'd9 : v;
  endfunction

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    logic        b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (b) begin
        if (r[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Preset for the current mode_sel
  always_comb begin
    case (mode_sel)
      2'b00:   preset = 16'h0000;
      2'b10:   preset = 16'h9999;
      default: preset = {clamp9(init_val_one), clamp9(init_val_two), 8'h00};
    endcase
  end

  // Next count value and terminal detection for the latched direction
  always_comb begin
    count_step    = down_q ? bcd_dec(count_q) : bcd_inc(count_q);
    step_terminal = down_q ? (count_step == 16'h0000) : (count_step == 16'h9999);
  end

  assign toggle_pulse = tog_sync_q[SYNC_STAGES-1] & ~tog_edge_q;
  assign tick         = (state_q == StRun) && (presc_q == PresW'(CLK_DIV - 1));
  // Counting down from 00.00 has nothing to do, so start goes straight to done
  assign idle_to_done = (state_q == StIdle) && toggle_pulse && mode_sel[1] &&
                        (preset == 16'h0000);
  assign run_to_done  = tick && step_terminal;

  // Toggle synchroniser and rising-edge detector
  always_ff @(posedge clock) begin
    if (reset) begin
      tog_sync_q <= '0;
      tog_edge_q <= 1'b0;
    end else begin
      tog_sync_q <= {tog_sync_q[SYNC_STAGES-2:0], toggle};
      tog_edge_q <= tog_sync_q[SYNC_STAGES-1];
    end
  end

  // Prescaler runs only in RUN and keeps its phase across pause
  always_ff @(posedge clock) begin
    if (reset) begin
      presc_q <= '0;
    end else if (state_q == StRun) begin
      presc_q <= tick ? '0 : presc_q + PresW'(1);
    end
  end

  // Run/pause/done state machine with registered digits and status
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      count_q   <= preset;
      down_q    <= mode_sel[1];
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          count_q <= preset;
          down_q  <= mode_sel[1];
          if (idle_to_done) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end else if (toggle_pulse) begin
            state_q   <= StRun;
            running_q <= 1'b1;
          end
        end
        StRun: begin
          if (tick) begin
            count_q <= count_step;
          end
          if (run_to_done) begin
            state_q   <= StDone;
            running_q <= 1'b0;
            done_q    <= 1'b1;
          end else if (toggle_pulse) begin
            state_q   <= StPause;
            running_q <= 1'b0;
          end
        end
        StPause: begin
          if (toggle_pulse) begin
            state_q   <= StRun;
            running_q <= 1'b1;
          end
        end
        default: ;  // StDone: only reset leaves
      endcase
    end
  end

`ifdef LAP_EN
  logic [SYNC_STAGES-1:0] lap_sync_q;
  logic                   lap_edge_q;
  logic                   freeze_q;
  logic [15:0]            snap_q;
  logic                   lap_pulse;

  assign lap_pulse = lap_sync_q[SYNC_STAGES-1] & ~lap_edge_q;

  // Lap synchroniser and rising-edge detector
  always_ff @(posedge clock) begin
    if (reset) begin
      lap_sync_q <= '0;
      lap_edge_q <= 1'b0;
    end else begin
      lap_sync_q <= {lap_sync_q[SYNC_STAGES-2:0], lap};
      lap_edge_q <= lap_sync_q[SYNC_STAGES-1];
    end
  end

  // Lap freeze: first pulse in RUN captures the count, second releases it
  always_ff @(posedge clock) begin
    if (reset) begin
      freeze_q <= 1'b0;
      snap_q   <= '0;
    end else if (idle_to_done || (state_q == StRun && run_to_done)) begin
      freeze_q <= 1'b0;
    end else if ((state_q == StRun) && lap_pulse) begin
      freeze_q <= ~freeze_q;
      if (!freeze_q) begin
        snap_q <= count_q;
      end
    end
  end

  assign shown = freeze_q ? snap_q : count_q;
`else
  assign shown = count_q;
`endif

  assign {digit0, digit1, digit2, digit3} = shown;
  assign running = running_q;
  assign done    = done_q;

endmodule
